// File: rtl/demux_1to8_deser.sv
// rtl/demux_1to8_deser.sv - serial-to-parallel 1:8 bit demultiplexer with valid/ready byte output
module demux_1to8_deser #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       sel_mode,
    input  logic [2:0] sel_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [7:0] fill_mask
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] work;
    logic [2:0] cnt;
    logic [2:0] pos;
    logic       accept;
    logic [7:0] work_upd;
    logic [7:0] mask_upd;
    logic       done;

    always_comb begin
        pos = sel_mode ? sel_in : (LSB_FIRST ? cnt : 3'd7 - cnt);
        accept = bit_valid & bit_ready;
        work_upd = work;
        work_upd[pos] = bit_in;
        mask_upd = fill_mask | (8'd1 << pos);
        // Completion means every position was written at least once in this byte.
        done = accept && (mask_upd == 8'hFF);
    end

    always_comb begin
        state_nxt  = state;
        bit_ready  = 1'b0;
        data_valid = 1'b0;
        case (state)
            FILL: begin
                bit_ready = !rst;
                if (done) state_nxt = HOLD;
            end
            HOLD: begin
                data_valid = 1'b1;
                if (data_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
        if (clear) state_nxt = FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            work      <= 8'h00;
            fill_mask <= 8'h00;
            cnt       <= 3'd0;
            data_out  <= 8'h00;
        end else begin
            state <= state_nxt;
            if (clear) begin
                fill_mask <= 8'h00;
                cnt       <= 3'd0;
            end else if (accept) begin
                work <= work_upd;
                if (done) begin
                    data_out  <= work_upd;
                    fill_mask <= 8'h00;
                    cnt       <= 3'd0;
                end else begin
                    fill_mask <= mask_upd;
                    if (!sel_mode) cnt <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_1to8_deser.sv
// tb/tb_demux_1to8_deser.sv - randomized and directed check of both bit orders against a reference model
module tb_demux_1to8_deser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sel_mode = 1'b0;
    logic [2:0] sel_in = 3'd0;
    logic       data_ready = 1'b0;

    logic       bit_ready_l, bit_ready_m;
    logic [7:0] data_out_l, data_out_m;
    logic       data_valid_l, data_valid_m;
    logic [7:0] fill_mask_l, fill_mask_m;

    demux_1to8_deser #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_l), .sel_mode(sel_mode), .sel_in(sel_in),
        .data_out(data_out_l), .data_valid(data_valid_l), .data_ready(data_ready),
        .fill_mask(fill_mask_l)
    );

    demux_1to8_deser #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_m), .sel_mode(sel_mode), .sel_in(sel_in),
        .data_out(data_out_m), .data_valid(data_valid_m), .data_ready(data_ready),
        .fill_mask(fill_mask_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: index 0 = LSB-first instance, index 1 = MSB-first instance.
    bit       m_hold [2];
    int       m_mask [2];
    int       m_cnt  [2];
    bit [7:0] m_work [2];
    bit [7:0] m_out  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step();
        int pos;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_hold[k] = 0; m_mask[k] = 0; m_cnt[k] = 0; m_work[k] = 0; m_out[k] = 0;
            end else if (clear) begin
                m_hold[k] = 0; m_mask[k] = 0; m_cnt[k] = 0;
            end else if (m_hold[k]) begin
                if (data_ready) m_hold[k] = 0;
            end else if (bit_valid) begin
                if (sel_mode) pos = int'(sel_in);
                else pos = (k == 0) ? m_cnt[k] : 7 - m_cnt[k];
                m_work[k][pos] = bit_in;
                m_mask[k] = m_mask[k] | (1 << pos);
                if (!sel_mode) m_cnt[k] = (m_cnt[k] + 1) % 8;
                if (m_mask[k] == 255) begin
                    m_out[k] = m_work[k]; m_hold[k] = 1; m_mask[k] = 0; m_cnt[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("l_data_out",   data_out_l,   m_out[0]);
        check("l_data_valid", data_valid_l, m_hold[0]);
        check("l_fill_mask",  fill_mask_l,  m_mask[0]);
        check("l_bit_ready",  bit_ready_l,  !m_hold[0] && !rst);
        check("m_data_out",   data_out_m,   m_out[1]);
        check("m_data_valid", data_valid_m, m_hold[1]);
        check("m_fill_mask",  fill_mask_m,  m_mask[1]);
        check("m_bit_ready",  bit_ready_m,  !m_hold[1] && !rst);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] bits_first_to_last);
        sel_mode  = 1'b0;
        bit_valid = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bit_in = bits_first_to_last[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        check("rst_data_out", data_out_l, 8'h00);
        rst = 1'b0;
        tick();
        check("idle_ready", bit_ready_l, 1'b1);

        // Stream 1,0,1,1,0,0,1,0
        send_byte(8'b1011_0010);
        check("lsb_byte", data_out_l, 8'h4D);
        check("msb_byte", data_out_m, 8'hB2);
        check("valid_lat1", data_valid_l, 1'b1);

        bit_valid = 1'b1; bit_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_stable", data_out_l, 8'h4D);
            check("hold_noready", bit_ready_l, 1'b0);
        end
        bit_valid = 1'b0;
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        check("handoff_valid", data_valid_l, 1'b0);
        check("handoff_keep", data_out_l, 8'h4D);

        // Explicit positions 7..0 with alternating bits
        sel_mode = 1'b1; bit_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel_in = 3'(7 - i);
            bit_in = (i % 2 == 0);
            tick();
        end
        bit_valid = 1'b0;
        check("explicit_aa", data_out_l, 8'hAA);
        data_ready = 1'b1; tick(); data_ready = 1'b0;

        sel_in = 3'd3; bit_valid = 1'b1;
        bit_in = 1'b0; tick();
        bit_in = 1'b1; tick();
        bit_valid = 1'b0;
        check("rewrite_mask", fill_mask_l, 8'h08);
        check("rewrite_nodone", data_valid_l, 1'b0);

        // clear mid-byte after 5 auto bits
        clear = 1'b1; tick(); clear = 1'b0;
        sel_mode = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        bit_valid = 1'b0;
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_mask", fill_mask_l, 8'h00);
        send_byte(8'hFF);
        check("after_clear_ff", data_out_l, 8'hFF);
        check("after_clear_ff_m", data_out_m, 8'hFF);

        clear = 1'b1; data_ready = 1'b1; tick();
        clear = 1'b0; data_ready = 1'b0;
        check("clear_in_hold", data_valid_l, 1'b0);
        check("clear_keeps_out", data_out_l, 8'hFF);

        // rst in HOLD and mid-byte
        send_byte(8'h5A);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_hold_out", data_out_l, 8'h00);
        check("rst_hold_valid", data_valid_l, 1'b0);
        bit_valid = 1'b1; bit_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bit_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_mid_mask", fill_mask_l, 8'h00);
        send_byte(8'h80);
        check("post_rst_lsb", data_out_l, 8'h01);
        check("post_rst_msb", data_out_m, 8'h80);
        data_ready = 1'b1; tick(); data_ready = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear      = ($urandom_range(0, 99) == 0);
            bit_valid  = ($urandom_range(0, 9) < 7);
            bit_in     = 1'($urandom);
            if ($urandom_range(0, 15) == 0) sel_mode = ~sel_mode;
            sel_in     = 3'($urandom);
            data_ready = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
